drlp_dma_bridge: RTL and testbench

- Sits directly downstream of drlp, between its DMA read/write ports and the shared memory interface.
- Buffers drlp result writes in a small FIFO and generates the write handshake pulse drlp waits on.
- Serialises writes and single-outstanding reads onto one valid/ready memory port, and returns read data to drlp's read buffer with a one-cycle ready pulse.
- A read never overtakes an earlier write: it is issued only after the write FIFO has drained.

---
 rtl/drlp_dma_bridge_if.sv | 41 ++++
 rtl/drlp_dma_bridge.sv | 134 +++++++++++++
 tb/tb_drlp_dma_bridge.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/drlp_dma_bridge_if.sv
// DMA and memory-side signal bundle for drlp_dma_bridge.
// The bridge takes the slave view; the driver of drlp/memory stimulus takes the master view.
interface drlp_dma_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_dma_wr_en;
    logic [ADDR_WIDTH-1:0] i_dma_wr_addr;
    logic [DATA_WIDTH-1:0] i_dma_wr_data;
    logic                  i_dma_rd_en;
    logic [ADDR_WIDTH-1:0] i_dma_rd_addr;
    logic [DATA_WIDTH-1:0] o_dma_rd_data;
    logic                  o_dma_rd_ready;
    logic                  o_hand_shaked;
    logic                  o_mem_v;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  i_mem_ready;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  i_mem_rdata_v;
    logic                  o_wfifo_full;
    logic                  o_overflow;
    logic                  o_busy;

    modport slave (
        input  i_dma_wr_en, i_dma_wr_addr, i_dma_wr_data, i_dma_rd_en, i_dma_rd_addr,
        input  i_mem_ready, i_mem_rdata, i_mem_rdata_v,
        output o_dma_rd_data, o_dma_rd_ready, o_hand_shaked,
        output o_mem_v, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_wfifo_full, o_overflow, o_busy
    );

    modport master (
        output i_dma_wr_en, i_dma_wr_addr, i_dma_wr_data, i_dma_rd_en, i_dma_rd_addr,
        output i_mem_ready, i_mem_rdata, i_mem_rdata_v,
        input  o_dma_rd_data, o_dma_rd_ready, o_hand_shaked,
        input  o_mem_v, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_wfifo_full, o_overflow, o_busy
    );
endinterface

// File: rtl/drlp_dma_bridge.sv
// Bridges drlp DMA writes (via a small FIFO) and single-outstanding reads onto one
// valid/ready memory port; reads wait until all earlier writes have drained.
module drlp_dma_bridge #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int WFIFO_ADDR_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    drlp_dma_bridge_if.slave   bus
);
    localparam int DEPTH = 1 << WFIFO_ADDR_WIDTH;
    localparam logic [WFIFO_ADDR_WIDTH:0] FULL_CNT = (WFIFO_ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} state_t;

    state_t                      state, state_nxt;
    logic [ADDR_WIDTH-1:0]       fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0]       fifo_data [DEPTH];
    logic [WFIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [WFIFO_ADDR_WIDTH:0]   count, count_nxt;
    logic                        push, pop, rd_capture, rd_done;
    logic                        rd_pend;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic                        mem_v, mem_we;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic                        rd_ready, hand_shaked, wfifo_full, overflow;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign pop        = (state == WR) && bus.i_mem_ready;
    assign push       = bus.i_dma_wr_en && ((count != FULL_CNT) || pop);
    assign rd_capture = !rd_pend && (state != RD_REQ) && (state != RD_WAIT) && bus.i_dma_rd_en;
    assign rd_done    = (state == RD_WAIT) && bus.i_mem_rdata_v;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        mem_v     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                // Same-cycle push/capture are looked at so the request goes out next cycle.
                if ((count != '0) || push)
                    state_nxt = WR;
                else if (rd_pend || rd_capture)
                    state_nxt = RD_REQ;
            end
            WR: begin
                mem_v     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr[rd_ptr];
                mem_wdata = fifo_data[rd_ptr];
                if (bus.i_mem_ready && (count_nxt == '0))
                    state_nxt = IDLE;
            end
            RD_REQ: begin
                mem_v    = 1'b1;
                mem_addr = rd_addr;
                if (bus.i_mem_ready)
                    state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.i_mem_rdata_v)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.i_dma_wr_addr;
            fifo_data[wr_ptr] <= bus.i_dma_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wfifo_full  <= 1'b0;
            overflow    <= 1'b0;
            hand_shaked <= 1'b0;
            rd_pend     <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
            rd_ready    <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            wfifo_full  <= (count_nxt == FULL_CNT);
            hand_shaked <= push;
            rd_ready    <= rd_done;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (bus.i_dma_wr_en && !push)
                overflow <= 1'b1;
            if (rd_capture) begin
                rd_pend <= 1'b1;
                rd_addr <= bus.i_dma_rd_addr;
            end else if (rd_done) begin
                rd_pend <= 1'b0;
            end
            if (rd_done)
                rd_data <= bus.i_mem_rdata;
        end
    end

    assign bus.o_mem_v        = mem_v;
    assign bus.o_mem_we       = mem_we;
    assign bus.o_mem_addr     = mem_addr;
    assign bus.o_mem_wdata    = mem_wdata;
    assign bus.o_dma_rd_data  = rd_data;
    assign bus.o_dma_rd_ready = rd_ready;
    assign bus.o_hand_shaked  = hand_shaked;
    assign bus.o_wfifo_full   = wfifo_full;
    assign bus.o_overflow     = overflow;
    assign bus.o_busy         = (state != IDLE) || (count != '0) || rd_pend;
endmodule

// File: tb/tb_drlp_dma_bridge.sv
// Directed-vector bench for drlp_dma_bridge: write path, overflow, ordering, reads,
// backpressure and reset during an outstanding read.
module tb_drlp_dma_bridge;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   rdy_cnt = 0;
    logic        acc_we[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_data[$];

    drlp_dma_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    drlp_dma_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WFIFO_ADDR_WIDTH(3)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change just after posedge, so negedge sees a settled request/accept pair.
    always @(negedge i_clk) begin
        if (i_rst_n && bus.o_mem_v && bus.i_mem_ready) begin
            acc_we.push_back(bus.o_mem_we);
            acc_addr.push_back(bus.o_mem_addr);
            acc_data.push_back(bus.o_mem_wdata);
        end
        if (bus.o_hand_shaked) hs_cnt++;
        if (bus.o_dma_rd_ready) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.o_dma_rd_data, bus.o_dma_rd_ready, bus.o_hand_shaked, bus.o_mem_v,
                  bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_wfifo_full,
                  bus.o_overflow, bus.o_busy}, '0);
    endtask

    initial begin
        int b, b2, base, found;
        bus.i_dma_wr_en = 0; bus.i_dma_wr_addr = 0; bus.i_dma_wr_data = 0;
        bus.i_dma_rd_en = 0; bus.i_dma_rd_addr = 0;
        bus.i_mem_ready = 0; bus.i_mem_rdata = 0; bus.i_mem_rdata_v = 0;

        repeat (3) @(posedge i_clk);
        #1;
        chk_zero("reset_outputs");
        i_rst_n = 1;
        tick();

        // Single write with memory always ready
        bus.i_mem_ready = 1;
        bus.i_dma_wr_en = 1; bus.i_dma_wr_addr = 32'h100; bus.i_dma_wr_data = 32'hDEADBEEF;
        tick();
        bus.i_dma_wr_en = 0;
        chk("wr1_handshake", bus.o_hand_shaked, 1);
        chk("wr1_req", {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata},
            {1'b1, 1'b1, 32'h100, 32'hDEADBEEF});
        tick();
        chk("wr1_idle", {bus.o_busy, bus.o_hand_shaked}, 2'b00);

        // Burst of 10 into a stalled memory port: 8 fit, 2 drop
        bus.i_mem_ready = 0;
        base = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.i_dma_wr_en = 1;
            bus.i_dma_wr_addr = 32'h1000 + 32'(i * 4);
            bus.i_dma_wr_data = 32'hA0000000 + 32'(i);
            tick();
        end
        bus.i_dma_wr_en = 0;
        tick();
        chk("burst_handshakes", 32'(hs_cnt - base), 8);
        chk("burst_full_ovf", {bus.o_wfifo_full, bus.o_overflow}, 2'b11);
        chk("burst_head", {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr}, {1'b1, 1'b1, 32'h1000});
        b = acc_addr.size();
        bus.i_mem_ready = 1;
        repeat (8) tick();
        chk("burst_drained", {bus.o_mem_v, bus.o_busy, bus.o_wfifo_full}, 3'b000);
        chk("burst_count", 32'(acc_addr.size() - b), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("burst_word%0d", i), {acc_we[b+i], acc_addr[b+i], acc_data[b+i]},
                {1'b1, 32'h1000 + 32'(i * 4), 32'hA0000000 + 32'(i)});
        chk("ovf_sticky", bus.o_overflow, 1);

        // Ordering: read requested while writes are queued
        b = acc_addr.size();
        bus.i_dma_wr_en = 1; bus.i_dma_wr_addr = 32'h2000; bus.i_dma_wr_data = 32'h1;
        tick();
        bus.i_dma_wr_addr = 32'h2004; bus.i_dma_wr_data = 32'h2;
        bus.i_dma_rd_en = 1; bus.i_dma_rd_addr = 32'h200;
        tick();
        bus.i_dma_wr_addr = 32'h2008; bus.i_dma_wr_data = 32'h3;
        bus.i_dma_rd_en = 0;
        tick();
        bus.i_dma_wr_en = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_mem_v && !bus.o_mem_we) begin found = 1; break; end
            tick();
        end
        chk("ord_rd_seen", found, 1);
        tick();
        tick();
        bus.i_mem_rdata_v = 1; bus.i_mem_rdata = 32'h12345678;
        base = rdy_cnt;
        tick();
        bus.i_mem_rdata_v = 0;
        chk("ord_rd_ready", {bus.o_dma_rd_ready, bus.o_dma_rd_data}, {1'b1, 32'h12345678});
        tick();
        chk("ord_rd_pulse_once", 32'(rdy_cnt - base), 1);
        chk("ord_rd_hold", bus.o_dma_rd_data, 32'h12345678);
        chk("ord_count", 32'(acc_addr.size() - b), 4);
        chk("ord_0", {acc_we[b], acc_addr[b]},     {1'b1, 32'h2000});
        chk("ord_1", {acc_we[b+1], acc_addr[b+1]}, {1'b1, 32'h2004});
        chk("ord_2", {acc_we[b+2], acc_addr[b+2]}, {1'b1, 32'h2008});
        chk("ord_3", {acc_we[b+3], acc_addr[b+3]}, {1'b0, 32'h200});

        // Held read request: next read only after one idle cycle
        bus.i_dma_rd_en = 1; bus.i_dma_rd_addr = 32'h300;
        tick();
        chk("rd_latency", {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata},
            {1'b1, 1'b0, 32'h300, 32'h0});
        tick();
        chk("rd_wait_novalid", bus.o_mem_v, 0);
        bus.i_mem_rdata_v = 1; bus.i_mem_rdata = 32'hCAFE0001;
        tick();
        bus.i_mem_rdata_v = 0;
        chk("rd_held_ready", {bus.o_dma_rd_ready, bus.o_dma_rd_data, bus.o_mem_v},
            {1'b1, 32'hCAFE0001, 1'b0});
        bus.i_dma_rd_addr = 32'h304;
        tick();
        chk("rd_reissue", {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr}, {1'b1, 1'b0, 32'h304});
        bus.i_dma_rd_en = 0;
        tick();
        bus.i_mem_rdata_v = 1; bus.i_mem_rdata = 32'h0BADF00D;
        tick();
        bus.i_mem_rdata_v = 0;
        chk("rd2_data", {bus.o_dma_rd_ready, bus.o_dma_rd_data}, {1'b1, 32'h0BADF00D});
        tick();
        chk("rd2_pulse_end", {bus.o_dma_rd_ready, bus.o_busy}, 2'b00);

        // Backpressure on a write
        bus.i_mem_ready = 0;
        bus.i_dma_wr_en = 1; bus.i_dma_wr_addr = 32'h400; bus.i_dma_wr_data = 32'h55AA55AA;
        tick();
        bus.i_dma_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_wr_c%0d", i), {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata},
                {1'b1, 1'b1, 32'h400, 32'h55AA55AA});
            tick();
        end
        b = acc_addr.size();
        bus.i_mem_ready = 1;
        tick();
        bus.i_mem_ready = 0;
        tick();
        chk("bp_wr_once", 32'(acc_addr.size() - b), 1);

        // Backpressure on a read request
        bus.i_dma_rd_en = 1; bus.i_dma_rd_addr = 32'h500;
        tick();
        bus.i_dma_rd_en = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rd_c%0d", i), {bus.o_mem_v, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata},
                {1'b1, 1'b0, 32'h500, 32'h0});
            tick();
        end
        b2 = acc_addr.size();
        bus.i_mem_ready = 1;
        tick();
        bus.i_mem_ready = 0;
        chk("bp_rd_once", {32'(acc_addr.size() - b2), bus.o_mem_v, bus.o_busy}, {32'd1, 1'b0, 1'b1});

        // Reset while waiting for read data; late data must be ignored
        i_rst_n = 0;
        #1;
        chk_zero("rst_mid_read");
        tick();
        i_rst_n = 1;
        base = rdy_cnt;
        bus.i_mem_rdata_v = 1; bus.i_mem_rdata = 32'hFFFF0000;
        tick();
        bus.i_mem_rdata_v = 0;
        tick();
        chk("rst_late_data", {32'(rdy_cnt - base), bus.o_dma_rd_data}, {32'd0, 32'd0});
        chk("rst_after", {bus.o_busy, bus.o_overflow, bus.o_mem_v}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
